// File: rtl/wavegen_multi.sv
`timescale 1ns/1ps
// wavegen_multi
//   Multi-waveform tone generator. A prescaler divides the clock by the
//   active tone divider. Each prescaler tick advances an OUT_W-bit phase
//   accumulator, and the registered sample is shaped from that phase.
//   Tone, mode and duty are held in shadow registers. The shadows reload
//   only when the phase rolls over, so any change lands on a period boundary.
//
// Ports
//   clk      : clock; all state changes on its rising edge
//   rst      : synchronous active-high reset; overrides en and loads the shadows
//   en       : run enable; low freezes all state and forces the strobes low
//   mode     : waveform select (0 saw, 1 triangle, 2 square, 3 pulse)
//   tonediv  : clocks per phase step; 0 halts the generator
//   duty     : pulse-mode threshold (out high while phase < duty)
//   out      : registered waveform sample
//   step     : one-cycle strobe after each phase advance
//   wrap     : one-cycle strobe after the phase rolls from all-ones to 0
module wavegen_multi #(
    parameter int OUT_W = 11,
    parameter int DIV_W = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [DIV_W-1:0] tonediv,
    input  logic [OUT_W-1:0] duty,
    output logic [OUT_W-1:0] out,
    output logic             step,
    output logic             wrap
);

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] act_div;
    logic [1:0]       act_mode;
    logic [OUT_W-1:0] act_duty;
    logic [OUT_W-1:0] phase;

    logic             tick;
    logic             rollover;
    logic [OUT_W-1:0] phase_nxt;
    logic [1:0]       mode_nxt;
    logic [OUT_W-1:0] duty_nxt;

    function automatic logic [OUT_W-1:0] shape(input logic [1:0]       m,
                                               input logic [OUT_W-1:0] p,
                                               input logic [OUT_W-1:0] d);
        logic [OUT_W-1:0] t;
        t = {p[OUT_W-2:0], 1'b0};
        case (m)
            2'd0:    shape = p;
            2'd1:    shape = p[OUT_W-1] ? ~t : t;
            2'd2:    shape = p[OUT_W-1] ? '0 : '1;
            default: shape = (p < d) ? '1 : '0;
        endcase
    endfunction

    // The sample is shaped from the settings in force after this edge.
    // On a rollover edge, those settings are the freshly loaded inputs.
    always_comb begin
        tick      = (act_div != '0) && (div_cnt == act_div - DIV_W'(1));
        rollover  = tick && (phase == '1);
        phase_nxt = phase + OUT_W'(1);
        mode_nxt  = rollover ? mode : act_mode;
        duty_nxt  = rollover ? duty : act_duty;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt  <= '0;
            phase    <= '0;
            out      <= '0;
            step     <= 1'b0;
            wrap     <= 1'b0;
            act_div  <= tonediv;
            act_mode <= mode;
            act_duty <= duty;
        end else if (en) begin
            step <= tick;
            wrap <= rollover;
            if (tick) begin
                // Every tick restarts the prescaler. After a rollover, the
                // first step of the new period therefore uses the new divider.
                div_cnt <= '0;
                phase   <= phase_nxt;
                out     <= shape(mode_nxt, phase_nxt, duty_nxt);
                if (rollover) begin
                    act_div  <= tonediv;
                    act_mode <= mode;
                    act_duty <= duty;
                end
            end else if (act_div != '0) begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end else begin
            step <= 1'b0;
            wrap <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wavegen_multi.sv
`timescale 1ns/1ps
// tb_wavegen_multi
//   Scoreboard bench for wavegen_multi. The driver applies one input vector
//   per clock. For each vector, a cycle-count reference model computes the
//   expected {out, step, wrap} and pushes it into a queue. A separate monitor
//   samples the DUT after each rising edge and compares against the popped
//   expectation.
module tb_wavegen_multi;

    localparam int OUT_W = 11;
    localparam int DIV_W = 11;
    localparam int NPH   = 1 << OUT_W;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic [1:0]       mode;
    logic [DIV_W-1:0] tonediv;
    logic [OUT_W-1:0] duty;
    logic [OUT_W-1:0] out;
    logic             step;
    logic             wrap;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int out;
        bit step;
        bit wrap;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state
    int m_cnt;    // cycles elapsed since the last phase step
    int m_phase;
    int m_out;
    int m_div;
    int m_mode;
    int m_duty;
    bit m_step;
    bit m_wrap;

    wavegen_multi #(.OUT_W(OUT_W), .DIV_W(DIV_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .mode    (mode),
        .tonediv (tonediv),
        .duty    (duty),
        .out     (out),
        .step    (step),
        .wrap    (wrap)
    );

    always #5 clk = ~clk;

    function automatic int wave(input int md, input int p, input int d);
        int half;
        int top;
        half = NPH / 2;
        top  = NPH - 1;
        case (md)
            0:       return p;
            1:       return (p < half) ? 2 * p : top - 2 * (p - half);
            2:       return (p < half) ? top : 0;
            default: return (p < d) ? top : 0;
        endcase
    endfunction

    task automatic cycle(input bit r, input bit e, input int md, input int td, input int dt);
        exp_t x;
        rst     = r;
        en      = e;
        mode    = 2'(md);
        tonediv = DIV_W'(td);
        duty    = OUT_W'(dt);
        if (r) begin
            m_cnt   = 0;
            m_phase = 0;
            m_out   = 0;
            m_step  = 0;
            m_wrap  = 0;
            m_div   = td % (1 << DIV_W);
            m_mode  = md % 4;
            m_duty  = dt % NPH;
        end else begin
            m_step = 0;
            m_wrap = 0;
            if (e && m_div != 0) begin
                m_cnt++;
                if (m_cnt == m_div) begin
                    m_cnt   = 0;
                    m_phase = (m_phase + 1) % NPH;
                    m_step  = 1;
                    if (m_phase == 0) begin
                        m_wrap = 1;
                        m_div  = td % (1 << DIV_W);
                        m_mode = md % 4;
                        m_duty = dt % NPH;
                    end
                    m_out = wave(m_mode, m_phase, m_duty);
                end
            end
        end
        x.out  = m_out;
        x.step = m_step;
        x.wrap = m_wrap;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n, input bit e, input int md, input int td, input int dt);
        for (int i = 0; i < n; i++) cycle(1'b0, e, md, td, dt);
    endtask

    // Monitor
    initial begin : monitor
        exp_t x;
        int   cyc;
        cyc = 0;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                checks++;
                if (int'(out) != x.out) begin
                    errors++;
                    $display("FAIL out cycle=%0d got=%0d want=%0d", cyc, out, x.out);
                end
                checks++;
                if (step != x.step) begin
                    errors++;
                    $display("FAIL step cycle=%0d got=%0b want=%0b", cyc, step, x.step);
                end
                checks++;
                if (wrap != x.wrap) begin
                    errors++;
                    $display("FAIL wrap cycle=%0d got=%0b want=%0b", cyc, wrap, x.wrap);
                end
            end
            cyc++;
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog time limit reached got=running want=finished");
        $fatal(1, "timeout");
    end

    initial begin : driver
        int md, td, dt;
        bit e;

        // Reset in saw mode at full rate, then run a full period plus a few steps
        cycle(1, 1, 0, 1, 0);
        cycle(1, 1, 0, 1, 0);
        run(2052, 1, 0, 1, 0);

        // Divide by 3, pause for 5 cycles, then resume
        cycle(1, 1, 0, 3, 0);
        run(20, 1, 0, 3, 0);
        run(5, 0, 0, 3, 0);
        run(20, 1, 0, 3, 0);

        // Change the divider and mode mid-period; they apply only after the wrap
        cycle(1, 1, 0, 2, 0);
        run(100, 1, 0, 2, 0);
        run(4096 + 40, 1, 2, 4, 0);

        // Triangle over a full period
        cycle(1, 1, 1, 1, 0);
        run(2060, 1, 1, 1, 0);

        // Pulse with duty 4, then with duty 0
        cycle(1, 1, 3, 1, 4);
        run(2060, 1, 3, 1, 4);
        cycle(1, 1, 3, 1, 0);
        run(2060, 1, 3, 1, 0);

        // Halted divider; then reset in the middle of a divide-by-5 period
        cycle(1, 1, 0, 0, 0);
        run(100, 1, 0, 0, 0);
        cycle(1, 1, 0, 5, 0);
        run(12, 1, 0, 5, 0);
        cycle(1, 1, 0, 5, 0);
        run(12, 1, 0, 5, 0);

        // Random stimulus with occasional resets and enable drops
        md = 0; td = 1; dt = 0;
        cycle(1, 1, md, td, dt);
        for (int i = 0; i < 4000; i++) begin
            if (i % 64 == 0) begin
                md = int'($urandom_range(0, 3));
                td = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : 1;
                dt = int'($urandom_range(0, NPH - 1));
            end
            e = ($urandom_range(0, 9) != 0);
            cycle(($urandom_range(0, 999) == 0), e, md, td, dt);
        end

        #5;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d want=0 pending expectations", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wavegen_multi.md
WAVEGEN_MULTI -- requirements
Module: wavegen_multi

Interface
REQ-001 The block SHALL have parameter OUT_W, default 11, giving the output sample width and phase width.
REQ-002 The block SHALL have parameter DIV_W, default 11, giving the tone-divider width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port en, input, 1 bit: run enable; low freezes all state.
REQ-006 The block SHALL have port mode, input, 2 bits: waveform select (0 saw, 1 triangle, 2 square, 3 pulse).
REQ-007 The block SHALL have port tonediv, input, DIV_W bits: clocks per phase step; 0 means halt.
REQ-008 The block SHALL have port duty, input, OUT_W bits: pulse-mode high threshold.
REQ-009 The block SHALL have port out, output, OUT_W bits: registered waveform sample.
REQ-010 The block SHALL have port step, output, 1 bit: one-cycle strobe on each phase advance.
REQ-011 The block SHALL have port wrap, output, 1 bit: one-cycle strobe when phase rolls over from all-ones to 0.

Function
REQ-012 Internal state SHALL be: prescaler div_cnt (DIV_W), phase (OUT_W), shadow registers act_div (DIV_W), act_mode (2) and act_duty (OUT_W).
REQ-013 When en=1 and act_div!=0, div_cnt SHALL count 0..act_div-1 and return to 0; a tick occurs in the cycle where div_cnt==act_div-1.
REQ-014 On a tick edge, phase SHALL increment by 1 modulo 2^OUT_W, step SHALL be 1 for the next cycle, and otherwise step SHALL be 0.
REQ-015 act_div=0 SHALL produce no ticks; div_cnt, phase and out hold; no strobes.
REQ-016 en=0 SHALL hold div_cnt, phase, out and the shadows; step and wrap SHALL be 0.
REQ-017 wrap SHALL be 1 for exactly the cycle after the tick edge on which phase moves from 2^OUT_W-1 to 0; wrap implies step.
REQ-018 On that wrap edge, the shadows SHALL load the current tonediv, mode and duty; at no other time (except reset) do they change. Parameter changes therefore take effect only at period boundaries.
REQ-019 On the wrap edge, div_cnt SHALL restart at 0 so that the new act_div governs the first step of the new period.
REQ-020 out SHALL update on the same edge as phase, computed from the new phase value p and the act_mode in effect after that edge.
REQ-021 Mode 0 (saw): out = p.
REQ-022 Mode 1 (triangle): let t = p[OUT_W-2:0] shifted left 1 with LSB 0. out = t if p[MSB]=0, else bitwise-NOT of t.
REQ-023 Mode 2 (square): out = all ones if p[MSB]=0, else 0.
REQ-024 Mode 3 (pulse): out = all ones if p < act_duty (unsigned), else 0; act_duty=0 gives constant 0.
REQ-025 All arithmetic SHALL be unsigned and width-truncated; no value SHALL saturate.
REQ-026 Latency SHALL be as follows: a tick cycle is followed by out, step and wrap valid on the next rising edge, i.e. 1 clock.

Reset
REQ-027 While rst=1 at a clock edge: div_cnt=0, phase=0, out=0, step=0, wrap=0; act_div, act_mode and act_duty load tonediv, mode and duty. rst SHALL override en.
REQ-028 Reset asserted mid-period SHALL abandon the period; after release the first step occurs act_div cycles later (en=1), with out computed per REQ-020.

Verification
REQ-029 Reset with mode=0, tonediv=1, en=1, then release: out SHALL be 1,2,3,... on consecutive cycles; after 2048 steps out=0 with wrap=1 for exactly that one cycle.
REQ-030 mode=0, tonediv=3: step SHALL pulse every 3rd cycle, and out SHALL advance by 1 per pulse; dropping en for 5 cycles SHALL freeze out and div_cnt, and timing resumes seamlessly.
REQ-031 Running in mode 0, change tonediv from 2 to 4 and mode to 2 mid-period: spacing SHALL stay 2 and the waveform saw until wrap; after wrap, out=2047 with steps every 4 cycles.
REQ-032 mode=1, tonediv=1: out SHALL be 2 at p=1, 2046 at p=1023, 2045 at p=1025, and 1 at p=2047.
REQ-033 mode=3, duty=4, tonediv=1: out SHALL be 2047 for p=1..3, 0 for p=4..2047, and 2047 at p=0; with duty=0, out SHALL be constantly 0.
REQ-034 tonediv=0 at reset: there SHALL be no step or wrap for 100 cycles, and out SHALL stay 0; asserting rst mid-period with tonediv=5 SHALL give out=0, with the first step 5 cycles after release.
